rtc_bus_bridge: RTL and testbench

Peripheral bridge directly downstream of the PICOBLAZE core. It decodes `port_id`/`out_port`/`write_strobe` and turns each processor command into one fully timed, multiplexed address/data bus cycle on the external RTC chip. It returns read data and status on `in_port` and can signal completion through `interrupt`/`interrupt_ack`.

---
 rtl/rtc_bridge_pkg.sv | 21 ++
 rtl/rtc_bus_bridge_if.sv | 21 ++
 rtl/rtc_phase_timer.sv | 21 ++
 rtl/rtc_bus_bridge.sv | 151 +++++++++++++++
 tb/tb_rtc_bus_bridge.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_bridge_pkg.sv
// Shared definitions for the PicoBlaze-to-RTC bridge: port map, STATUS layout,
// and the bus-cycle FSM state encoding.
package rtc_bridge_pkg;

  localparam logic [7:0] PORT_ADDR   = 8'h01;
  localparam logic [7:0] PORT_WDATA  = 8'h02;
  localparam logic [7:0] PORT_RD     = 8'h03;
  localparam logic [7:0] PORT_RDATA  = 8'h04;
  localparam logic [7:0] PORT_STATUS = 8'h05;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  localparam int TMR_W = 4;

  typedef enum logic [2:0] {
    IDLE, A_SU, A_PW, A_HD, D_SU, D_PW, D_HD, DONE
  } state_e;

endpackage

// File: rtl/rtc_bus_bridge_if.sv
// Multiplexed address/data bus to the external RTC chip; the top level builds
// the tristate from rtc_bus_out/rtc_bus_oe.
interface rtc_bus_bridge_if;
  logic       rtc_cs_n;
  logic       rtc_rd_n;
  logic       rtc_wr_n;
  logic       rtc_ad;
  logic [7:0] rtc_bus_out;
  logic       rtc_bus_oe;
  logic [7:0] rtc_bus_in;

  modport master (
    output rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad, rtc_bus_out, rtc_bus_oe,
    input  rtc_bus_in
  );

  modport slave (
    input  rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad, rtc_bus_out, rtc_bus_oe,
    output rtc_bus_in
  );
endinterface

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter shared by every timed bus phase; zero marks the last
// cycle of the current phase.
module rtc_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/rtc_bus_bridge.sv
// PicoBlaze port decoder driving one timed address+data cycle on the RTC bus.
// Optional feature macro: RTC_BRIDGE_IRQ_EN (completion interrupt).
module rtc_bus_bridge
  import rtc_bridge_pkg::*;
#(
  parameter int T_SU = 2,
  parameter int T_PW = 10,
  parameter int T_HD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       port_id,
  input  logic [7:0]       out_port,
  input  logic             write_strobe,
  input  logic             read_strobe,
  input  logic             interrupt_ack,
  output logic [7:0]       in_port,
  output logic             interrupt,
  rtc_bus_bridge_if.master rtc
);
  localparam logic [TMR_W-1:0] SU_LD = TMR_W'(T_SU - 1);
  localparam logic [TMR_W-1:0] PW_LD = TMR_W'(T_PW - 1);
  localparam logic [TMR_W-1:0] HD_LD = TMR_W'(T_HD - 1);

  state_e           state, state_nx;
  logic [7:0]       addr_q, wdata_q, rdata_q, status;
  logic             dir_rd_q, done_q, err_q;
  logic             busy, start_cmd, status_clr, zero, load;
  logic [TMR_W-1:0] load_val;

  assign busy       = (state != IDLE);
  assign start_cmd  = write_strobe && (port_id == PORT_WDATA || port_id == PORT_RD);
  assign status_clr = read_strobe && (port_id == PORT_STATUS);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_cmd) state_nx = A_SU;
      A_SU:    if (zero) state_nx = A_PW;
      A_PW:    if (zero) state_nx = A_HD;
      A_HD:    if (zero) state_nx = D_SU;
      D_SU:    if (zero) state_nx = D_PW;
      D_PW:    if (zero) state_nx = D_HD;
      D_HD:    if (zero) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Reload on every state change so each phase runs exactly its own length.
  always_comb begin
    load     = (state_nx != state);
    load_val = '0;
    case (state_nx)
      A_SU, D_SU: load_val = SU_LD;
      A_PW, D_PW: load_val = PW_LD;
      A_HD, D_HD: load_val = HD_LD;
      default:    load_val = '0;
    endcase
  end

  rtc_phase_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  always_comb begin
    rtc.rtc_cs_n    = 1'b1;
    rtc.rtc_rd_n    = 1'b1;
    rtc.rtc_wr_n    = 1'b1;
    rtc.rtc_ad      = 1'b0;
    rtc.rtc_bus_out = 8'h00;
    rtc.rtc_bus_oe  = 1'b0;
    case (state)
      A_SU, A_PW, A_HD: begin
        rtc.rtc_cs_n    = 1'b0;
        rtc.rtc_bus_out = addr_q;
        rtc.rtc_bus_oe  = 1'b1;
        rtc.rtc_wr_n    = (state != A_PW);
      end
      D_SU, D_PW, D_HD: begin
        rtc.rtc_cs_n    = 1'b0;
        rtc.rtc_ad      = 1'b1;
        rtc.rtc_bus_out = dir_rd_q ? 8'h00 : wdata_q;
        rtc.rtc_bus_oe  = !dir_rd_q;
        rtc.rtc_rd_n    = !(state == D_PW && dir_rd_q);
        rtc.rtc_wr_n    = !(state == D_PW && !dir_rd_q);
      end
      default: ;
    endcase
  end

  always_comb begin
    status          = 8'h00;
    status[ST_BUSY] = busy;
    status[ST_DONE] = done_q;
    status[ST_ERR]  = err_q;
  end

  // Completion/collision flags: a set in the same cycle as a status read wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      rdata_q  <= 8'h00;
      dir_rd_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      in_port  <= 8'h00;
    end else begin
      if (!busy && write_strobe && port_id == PORT_ADDR)  addr_q  <= out_port;
      if (!busy && write_strobe && port_id == PORT_WDATA) wdata_q <= out_port;
      if (!busy && start_cmd) dir_rd_q <= (port_id == PORT_RD);
      if (state == D_PW && zero && dir_rd_q) rdata_q <= rtc.rtc_bus_in;

      if (state == DONE)    done_q <= 1'b1;
      else if (status_clr)  done_q <= 1'b0;

      if (busy && start_cmd) err_q <= 1'b1;
      else if (status_clr)   err_q <= 1'b0;

      case (port_id)
        PORT_RDATA:  in_port <= rdata_q;
        PORT_STATUS: in_port <= status;
        default:     in_port <= 8'h00;
      endcase
    end
  end

`ifdef RTC_BRIDGE_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk) begin
    if (rst)                irq_q <= 1'b0;
    else if (state == DONE) irq_q <= 1'b1;
    else if (interrupt_ack) irq_q <= 1'b0;
  end
  assign interrupt = irq_q | (state == DONE);
`else
  logic unused_ack;
  assign unused_ack = interrupt_ack;
  assign interrupt  = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_bus_bridge.sv
// Directed bench for rtc_bus_bridge: a per-cycle transaction-offset model plus
// literal checkpoints from the bring-up scenarios.
module tb_rtc_bus_bridge;
  localparam int SU = 2, PW = 10, HD = 2;
  localparam int L  = SU + PW + HD;
  localparam int DN = 2 * L + 1;
`ifdef RTC_BRIDGE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] port_id = 8'h00, out_port = 8'h00;
  logic       write_strobe = 1'b0, read_strobe = 1'b0, interrupt_ack = 1'b0;
  logic [7:0] in_port;
  logic       interrupt;
  logic [7:0] chip_data = 8'h00;
  bit         chk_en = 1'b0;
  int         n_cmp = 0, n_err = 0;

  rtc_bus_bridge_if bus ();
  assign bus.rtc_bus_in = bus.rtc_rd_n ? 8'h00 : chip_data;

  rtc_bus_bridge #(.T_SU(SU), .T_PW(PW), .T_HD(HD)) dut (
    .clk           (clk),
    .rst           (rst),
    .port_id       (port_id),
    .out_port      (out_port),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .interrupt_ack (interrupt_ack),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .rtc           (bus)
  );

  always #5 clk = ~clk;

  task automatic chk8(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b @%0t", name, act, exp, $time);
    end
  endtask

  // Model: m_k is the cycle offset since the start strobe (1..DN), DN = DONE.
  bit         m_active = 0, m_rd = 0, m_done = 0, m_err = 0, m_irq = 0;
  int         m_k = 0;
  logic [7:0] m_addr = 0, m_wdata = 0, m_rdata = 0, m_inp = 0;
  int         cnt_a21 = 0, cnt_d59 = 0, cnt_rd_lo = 0, cnt_cs_lo = 0;

  task automatic compare();
    int k, j;
    bit aph, dph, pulse, e_oe;
    k     = m_active ? m_k : 0;
    aph   = m_active && k <= L;
    dph   = m_active && k > L && k <= 2 * L;
    j     = dph ? k - L : k;
    pulse = (aph || dph) && j > SU && j <= SU + PW;
    e_oe  = aph || (dph && !m_rd);
    chk1("cs_n", bus.rtc_cs_n, !(aph || dph));
    chk1("ad", bus.rtc_ad, dph);
    chk1("oe", bus.rtc_bus_oe, e_oe);
    chk1("wr_n", bus.rtc_wr_n, !(pulse && (aph || !m_rd)));
    chk1("rd_n", bus.rtc_rd_n, !(pulse && dph && m_rd));
    if (e_oe) chk8("bus_out", bus.rtc_bus_out, aph ? m_addr : m_wdata);
    chk8("in_port", in_port, m_inp);
    chk1("interrupt", interrupt, IRQ_EN && (m_irq || (m_active && k == DN)));
    chk1("strobe_excl", bus.rtc_rd_n | bus.rtc_wr_n, 1'b1);
    chk1("oe_vs_rd", bus.rtc_bus_oe & ~bus.rtc_rd_n, 1'b0);
    if (!bus.rtc_cs_n) cnt_cs_lo++;
    if (!bus.rtc_rd_n) cnt_rd_lo++;
    if (!bus.rtc_wr_n && !bus.rtc_ad && bus.rtc_bus_oe && bus.rtc_bus_out == 8'h21) cnt_a21++;
    if (!bus.rtc_wr_n && bus.rtc_ad && bus.rtc_bus_oe && bus.rtc_bus_out == 8'h59) cnt_d59++;
  endtask

  task automatic model_step();
    bit busy, is_done, start_req;
    logic [7:0] st;
    if (rst) begin
      m_active = 0; m_k = 0; m_rd = 0; m_done = 0; m_err = 0; m_irq = 0;
      m_addr = 0; m_wdata = 0; m_rdata = 0; m_inp = 0;
    end else begin
      busy      = m_active;
      is_done   = m_active && m_k == DN;
      start_req = write_strobe && (port_id == 8'h02 || port_id == 8'h03);
      st        = {5'b0, m_err, m_done, busy};
      m_inp     = (port_id == 8'h04) ? m_rdata : (port_id == 8'h05) ? st : 8'h00;
      if (m_active && m_rd && m_k == L + SU + PW) m_rdata = chip_data;
      if (read_strobe && port_id == 8'h05) begin m_done = 0; m_err = 0; end
      if (write_strobe && port_id == 8'h01 && !busy) m_addr = out_port;
      if (start_req && busy) m_err = 1;
      if (is_done) m_done = 1;
      if (is_done) m_irq = 1;
      else if (interrupt_ack) m_irq = 0;
      if (busy) begin
        if (m_k == DN) m_active = 0;
        else m_k++;
      end else if (start_req) begin
        m_active = 1; m_k = 1; m_rd = (port_id == 8'h03);
        if (port_id == 8'h02) m_wdata = out_port;
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) compare();
    model_step();
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic io_out(input logic [7:0] p, input logic [7:0] d);
    port_id = p; out_port = d; write_strobe = 1'b1;
    cyc();
    write_strobe = 1'b0;
  endtask

  task automatic io_in(input logic [7:0] p, input logic rs, output logic [7:0] v);
    port_id = p; read_strobe = rs;
    cyc();
    read_strobe = 1'b0;
    v = in_port;
  endtask

  initial begin
    logic [7:0] v;
    int a0, d0, r0, c0;
    repeat (2) cyc();
    chk_en = 1'b1;
    repeat (2) cyc();
    chk1("rst_cs_n", bus.rtc_cs_n, 1'b1);
    chk1("rst_rd_n", bus.rtc_rd_n, 1'b1);
    chk1("rst_wr_n", bus.rtc_wr_n, 1'b1);
    chk1("rst_oe", bus.rtc_bus_oe, 1'b0);
    chk1("rst_ad", bus.rtc_ad, 1'b0);
    chk8("rst_bus_out", bus.rtc_bus_out, 8'h00);
    chk8("rst_in_port", in_port, 8'h00);
    chk1("rst_irq", interrupt, 1'b0);
    rst = 1'b0;
    cyc();
    io_in(8'h05, 1'b1, v); chk8("status_after_rst", v, 8'h00);

    // write 0x59 to RTC address 0x21
    a0 = cnt_a21; d0 = cnt_d59;
    io_out(8'h01, 8'h21);
    io_out(8'h02, 8'h59);
    repeat (28) cyc();
    chk1("irq_at_done", interrupt, IRQ_EN);
    io_in(8'h05, 1'b0, v); chk8("status_in_done", v, 8'h01);
    chk1("irq_held", interrupt, IRQ_EN);
    interrupt_ack = 1'b1;
    io_in(8'h05, 1'b1, v); chk8("status_after_29", v, 8'h02);
    interrupt_ack = 1'b0;
    chk1("irq_after_ack", interrupt, 1'b0);
    chk8("wr_addr_pw", 8'(cnt_a21 - a0), 8'd10);
    chk8("wr_data_pw", 8'(cnt_d59 - d0), 8'd10);

    // read from RTC address 0x22, chip answers 0x47
    chip_data = 8'h47; r0 = cnt_rd_lo;
    io_out(8'h01, 8'h22);
    io_out(8'h03, 8'h00);
    repeat (30) cyc();
    io_in(8'h04, 1'b1, v); chk8("rdata", v, 8'h47);
    chk8("rd_pw", 8'(cnt_rd_lo - r0), 8'd10);
    io_in(8'h05, 1'b1, v); chk8("status_read", v, 8'h02);

    // commands while busy are rejected
    io_out(8'h01, 8'h30);
    io_out(8'h02, 8'hA5);
    repeat (4) cyc();
    io_out(8'h02, 8'h11);
    io_out(8'h01, 8'h77);
    io_out(8'h03, 8'h00);
    repeat (30) cyc();
    io_in(8'h05, 1'b1, v); chk8("collide_status", v, 8'h06);
    io_in(8'h05, 1'b1, v); chk8("collide_cleared", v, 8'h00);

    // start strobe landing on the DONE cycle
    io_out(8'h02, 8'h10);
    repeat (28) cyc();
    io_out(8'h02, 8'h33);
    io_in(8'h05, 1'b1, v); chk8("done_collide", v, 8'h06);
    c0 = cnt_cs_lo;
    repeat (3) cyc();
    chk8("no_restart", 8'(cnt_cs_lo - c0), 8'd0);

    // reset in the middle of the data strobe
    io_out(8'h02, 8'h5A);
    repeat (19) cyc();
    io_out(8'h03, 8'h00);
    chk1("pre_rst_wr_n", bus.rtc_wr_n, 1'b0);
    rst = 1'b1;
    cyc();
    chk1("mid_rst_cs_n", bus.rtc_cs_n, 1'b1);
    chk1("mid_rst_wr_n", bus.rtc_wr_n, 1'b1);
    chk1("mid_rst_rd_n", bus.rtc_rd_n, 1'b1);
    chk1("mid_rst_irq", interrupt, 1'b0);
    repeat (4) cyc();
    rst = 1'b0;
    cyc();
    io_in(8'h05, 1'b1, v); chk8("status_post_rst", v, 8'h00);

    // unknown port
    c0 = cnt_cs_lo;
    io_out(8'h7F, 8'hFF);
    repeat (3) cyc();
    chk8("unk_no_bus", 8'(cnt_cs_lo - c0), 8'd0);
    io_in(8'h7F, 1'b1, v); chk8("unk_read", v, 8'h00);

    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
